// File: rtl/usb_pkg.sv
// usb_pkg: shared FSM states, timing constants and USB line encodings for the transmitter.
package usb_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE     = 3'd0;
  localparam state_t TX_SYNC  = 3'd1;
  localparam state_t TX_DATA  = 3'd2;
  localparam state_t TX_STUFF = 3'd3;
  localparam state_t TX_EOP   = 3'd4;
  localparam state_t TX_J     = 3'd5;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam int CLKS_PER_BIT = 8;
  localparam int STUFF_LIMIT = 6;
  localparam int FIFO_DEPTH = 8;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  function automatic logic [1:0] nrzi(input logic [1:0] line, input logic b);
    return b ? line : (line == LINE_J ? LINE_K : LINE_J);
  endfunction
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: 8x8 transmit FIFO with registered full/empty; a push while full succeeds only alongside a pop.
module tx_fifo
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] w_data,
  output logic [7:0] r_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q, full_d, empty_q, empty_d, wr, rd;
  logic [7:0] mem_q [FIFO_DEPTH];
  always_comb begin
    rd = pop && !empty_q;
    wr = push && (!full_q || rd);
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(rd);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    full_d = cnt_d == (AW+1)'(FIFO_DEPTH);
    empty_d = cnt_d == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wptr_q] <= w_data;
  assign r_data = mem_q[rptr_q];
  assign full = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/usb_transmitter.sv
// usb_transmitter: sends FIFO bytes as one USB packet (SYNC, NRZI data with bit stuffing, EOP).
module usb_transmitter
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       w_enable,
  input  logic [7:0] w_data,
  input  logic       send,
  output logic       d_plus,
  output logic       d_minus,
  output logic       transmitting,
  output logic       empty,
  output logic       full,
  output logic       tx_done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] bit_q, bit_d, ones_q, ones_d;
  logic [7:0] shift_q, shift_d, fifo_data;
  logic [1:0] line_q, line_d;
  logic done_q, done_d;
  logic start, bit_end, stuff_due, byte_end, advance, pop, emit, emit_bit;
  tx_fifo u_fifo (
    .clk(clk), .rst(rst), .push(w_enable), .pop(pop), .w_data(w_data),
    .r_data(fifo_data), .full(full), .empty(empty)
  );
  // state_q names the kind of bit currently on the line; every decision happens at its last clock
  always_comb begin
    start = state_q == IDLE && send && !empty;
    bit_end = timer_q == TW'(CLKS_PER_BIT - 1);
    stuff_due = ones_q == 3'(STUFF_LIMIT);
    byte_end = bit_q == 3'd7;
    advance = bit_end && (state_q == TX_STUFF || ((state_q == TX_SYNC || state_q == TX_DATA) && !stuff_due));
    pop = advance && byte_end && !empty;
    emit = start || (advance && (!byte_end || pop));
    emit_bit = start ? SYNC_BYTE[0] : pop ? fifo_data[0] : shift_q[bit_q + 3'd1];
    state_d = state_q;
    timer_d = state_q == IDLE ? '0 : timer_q + TW'(1);
    bit_d = bit_q;
    ones_d = ones_q;
    shift_d = shift_q;
    line_d = line_q;
    done_d = 1'b0;
    if (emit) begin
      line_d = nrzi(line_q, emit_bit);
      ones_d = emit_bit ? ones_q + 3'd1 : 3'd0;
    end
    if (start) begin
      state_d = TX_SYNC;
      shift_d = SYNC_BYTE;
      bit_d = 3'd0;
      timer_d = '0;
    end else if (bit_end) begin
      if ((state_q == TX_SYNC || state_q == TX_DATA) && stuff_due) begin
        state_d = TX_STUFF;
        line_d = nrzi(line_q, 1'b0);
        ones_d = 3'd0;
      end else if (pop) begin
        state_d = TX_DATA;
        shift_d = fifo_data;
        bit_d = 3'd0;
      end else if (advance && !byte_end) begin
        state_d = state_q == TX_STUFF ? TX_DATA : state_q;
        bit_d = bit_q + 3'd1;
      end else if (advance) begin
        state_d = TX_EOP;
        line_d = LINE_SE0;
        bit_d = 3'd0;
        ones_d = 3'd0;
      end else if (state_q == TX_EOP) begin
        state_d = bit_q == 3'd1 ? TX_J : TX_EOP;
        line_d = bit_q == 3'd1 ? LINE_J : LINE_SE0;
        bit_d = bit_q + 3'd1;
      end else if (state_q == TX_J) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q <= 3'd0;
      ones_q <= 3'd0;
      shift_q <= 8'd0;
      line_q <= LINE_J;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q <= bit_d;
      ones_q <= ones_d;
      shift_q <= shift_d;
      line_q <= line_d;
      done_q <= done_d;
    end
  assign {d_plus, d_minus} = line_q;
  assign transmitting = state_q != IDLE;
  assign tx_done = done_q;
endmodule

// File: doc/usb_transmitter.md
USB_TRANSMITTER -- requirements
Module: usb_transmitter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge system clock, 8 clocks per USB bit) and rst (input, 1, async active-high reset).
REQ-002 w_enable SHALL be an input, width 1: when high, push w_data into the transmit FIFO.
REQ-003 w_data SHALL be an input, width 8: the packet byte, transmitted LSB first.
REQ-004 send SHALL be an input, width 1: request to transmit the FIFO contents as one packet.
REQ-005 d_plus SHALL be an output, width 1: the registered USB D+ line.
REQ-006 d_minus SHALL be an output, width 1: the registered USB D- line.
REQ-007 transmitting SHALL be an output, width 1: high from leaving IDLE until returning to IDLE.
REQ-008 empty and full SHALL be outputs, width 1 each: the transmit FIFO status flags.
REQ-009 tx_done SHALL be an output, width 1: a one-clock pulse on return to IDLE after EOP.

Function
REQ-010 Line encodings SHALL be: J = (d_plus 1, d_minus 0), K = (0, 1), SE0 = (0, 0); the line is J whenever the block is in IDLE.
REQ-011 The bit timer SHALL count 0..7; d_plus/d_minus change only on the clock edge where the timer wraps to 0, so every bit lasts exactly 8 clocks.
REQ-012 NRZI encoding SHALL apply: a 0 bit toggles the line between J and K; a 1 bit holds the current level.
REQ-013 The FSM SHALL have the states IDLE, TX_SYNC, TX_DATA, TX_STUFF, TX_EOP and TX_J.
REQ-014 IDLE->TX_SYNC SHALL occur when send is high and empty is low; send is ignored when the FIFO is empty or the block is not in IDLE.
REQ-015 The first SYNC bit SHALL appear on the line 1 clock after send is sampled.
REQ-016 TX_SYNC SHALL send 8'h80 LSB first (seven 0s then one 1), giving the line sequence KJKJKJKK.
REQ-017 At the end of SYNC and at the end of each data byte, the block SHALL pop the FIFO head into the shift register if the FIFO is not empty; otherwise it SHALL go to TX_EOP.
REQ-018 Bit stuffing: a ones-counter SHALL count consecutive transmitted 1s, including the trailing 1 of SYNC.
REQ-019 When the ones-counter reaches 6, the block SHALL enter TX_STUFF for one bit period, emit a 0 (toggle), and clear the counter; the interrupted byte then resumes.
REQ-020 A 0 bit SHALL clear the ones-counter.
REQ-021 A stuff bit that is due after the last data bit SHALL be sent before EOP.
REQ-022 TX_EOP SHALL drive SE0 for 2 bit periods (16 clocks); TX_J SHALL then drive J for 1 bit period; the block then enters IDLE and pulses tx_done.
REQ-023 FIFO: 8 entries of 8 bits; a write when full is dropped with no state change; writes are accepted during transmission (streaming).
REQ-024 A simultaneous write and pop SHALL both take effect, including when the FIFO is full.
REQ-025 full and empty SHALL be registered and SHALL reflect the occupancy after the current edge.

Reset
REQ-026 While rst is high, the block SHALL force the line to J (d_plus 1, d_minus 0) and set transmitting 0, tx_done 0, empty 1 and full 0.
REQ-027 While rst is high, the state SHALL be IDLE, the bit timer and ones-counter SHALL be 0, and the FIFO pointers and count SHALL be cleared.
REQ-028 Reset asserted mid-packet SHALL abort the packet immediately with no EOP; after release, a new send operates normally.

Structure
REQ-029 Package usb_pkg SHALL hold the state enum, SYNC_BYTE = 8'h80, CLKS_PER_BIT = 8, STUFF_LIMIT = 6, FIFO_DEPTH = 8, and the J/K/SE0 line encodings.
REQ-030 The FIFO SHALL be the sub-module tx_fifo (8x8, with full/empty outputs); the FSM, bit timer, shift register, NRZI and stuffing logic SHALL reside in usb_transmitter.

Verification
REQ-031 Reset test: pulse rst -> line J, empty 1, full 0, transmitting 0; send with the FIFO empty -> line stays J.
REQ-032 Single-byte test: write 8'hA5, then send -> line KJKJKJKK then KJJKJJKK (8 clocks per bit, 128 clocks total), then SE0 for 16 clocks, J for 8 clocks, and a tx_done pulse; empty is 1 after the pop.
REQ-033 Stuffing test: write 8'hFF, then send -> after SYNC and five data 1s, one stuff toggle is inserted; 17 bit periods precede EOP; the line holds its level across each run of 1s.
REQ-034 Back-to-back test: write 8'h3C and 8'hC3, then send -> both bytes are sent with no gap and a single EOP; empty rises at the second pop.
REQ-035 Overflow test: write 9 bytes -> full rises after the 8th write and the 9th byte is dropped; send transmits exactly 8 bytes.
REQ-036 Abort test: assert rst during the 4th data bit -> line J immediately and transmitting 0; a subsequent write of 8'h01 and send yields a correct packet.
